// File: rtl/instruction_encoder_pkg.sv
// Shared format codes, opcodes and FSM states for the RV32I instruction encoder.
// Range checks are expressed as "bits under mask are all equal" tests.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_LI   = 3'd5,
    FMT_RSV6 = 3'd6,
    FMT_RSV7 = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    HOLD_LAST  = 2'd1,
    HOLD_FIRST = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;

  localparam logic [31:0] MASK_12 = 32'hFFFF_F800;
  localparam logic [31:0] MASK_13 = 32'hFFFF_F000;
  localparam logic [31:0] MASK_21 = 32'hFFF0_0000;

  // True when every bit of v selected by mask has the same value (sign run).
  function automatic logic fits_upper(input logic [31:0] v, input logic [31:0] mask);
    return ((v & mask) == mask) || ((v & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/instruction_packer.sv
// Combinational packer: places register fields and an immediate into one
// I/S/B/U/J instruction word and flags immediates that do not fit.
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        error
);

  always_comb begin
    inst  = 32'd0;
    error = 1'b0;
    case (fmt)
      FMT_I: begin
        inst  = {imm[11:0], rs1, funct3, rd, opcode};
        error = !fits_upper(imm, MASK_12);
      end
      FMT_S: begin
        inst  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        error = !fits_upper(imm, MASK_12);
      end
      FMT_B: begin
        inst  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        error = imm[0] || !fits_upper(imm, MASK_13);
      end
      FMT_U: begin
        inst  = {imm[31:12], rd, opcode};
        error = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        inst  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        error = imm[0] || !fits_upper(imm, MASK_21);
      end
      default: begin
        inst  = 32'd0;
        error = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Encodes instruction requests (including the LI pseudo-format, which may expand
// to LUI+ADDI) and streams the words through a registered valid/ready output.
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_format,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_last,
  output logic        inst_error
);

  state_e      state;
  logic [4:0]  pend_rd;
  logic [11:0] pend_lo;

  logic        req_fire;
  logic        is_li;
  logic        li_fits;
  logic        li_two;
  logic [19:0] li_hi;
  logic [2:0]  pk_fmt;
  logic [6:0]  pk_opcode;
  logic [2:0]  pk_funct3;
  logic [4:0]  pk_rs1;
  logic [31:0] pk_imm;
  logic [31:0] req_word;
  logic        req_err;
  logic [31:0] pend_word;
  logic        pend_err;

  assign req_ready = (state == EMPTY) || ((state == HOLD_LAST) && inst_ready);
  assign req_fire  = req_valid && req_ready;

  // LI is rewritten here into either ADDI rd,x0,lo or LUI rd,hi for the packer;
  // hi is rounded up by imm[11] so that hi + sign-extended lo gives back imm.
  always_comb begin
    is_li     = (req_format == FMT_LI);
    li_fits   = fits_upper(req_imm, MASK_12);
    li_hi     = req_imm[31:12] + {19'd0, req_imm[11]};
    li_two    = is_li && !li_fits && (req_imm[11:0] != 12'd0);
    pk_fmt    = req_format;
    pk_opcode = req_opcode;
    pk_funct3 = req_funct3;
    pk_rs1    = req_rs1;
    pk_imm    = req_imm;
    if (is_li) begin
      pk_funct3 = 3'd0;
      pk_rs1    = 5'd0;
      if (li_fits) begin
        pk_fmt    = FMT_I;
        pk_opcode = OPCODE_OP_IMM;
        pk_imm    = {{20{req_imm[11]}}, req_imm[11:0]};
      end else begin
        pk_fmt    = FMT_U;
        pk_opcode = OPCODE_LUI;
        pk_imm    = {li_hi, 12'd0};
      end
    end
  end

  instruction_packer u_req_packer (
    .fmt    (pk_fmt),
    .opcode (pk_opcode),
    .funct3 (pk_funct3),
    .rd     (req_rd),
    .rs1    (pk_rs1),
    .rs2    (req_rs2),
    .imm    (pk_imm),
    .inst   (req_word),
    .error  (req_err)
  );

  instruction_packer u_pend_packer (
    .fmt    (FMT_I),
    .opcode (OPCODE_OP_IMM),
    .funct3 (3'd0),
    .rd     (pend_rd),
    .rs1    (pend_rd),
    .rs2    (5'd0),
    .imm    ({{20{pend_lo[11]}}, pend_lo}),
    .inst   (pend_word),
    .error  (pend_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_last  <= 1'b0;
      inst_error <= 1'b0;
      pend_rd    <= 5'd0;
      pend_lo    <= 12'd0;
    end else if (req_fire) begin
      inst_valid <= 1'b1;
      inst       <= req_word;
      inst_error <= is_li ? 1'b0 : req_err;
      inst_last  <= !li_two;
      state      <= li_two ? HOLD_FIRST : HOLD_LAST;
      if (li_two) begin
        pend_rd <= req_rd;
        pend_lo <= req_imm[11:0];
      end
    end else if (inst_ready) begin
      case (state)
        HOLD_FIRST: begin
          inst       <= pend_word;
          inst_error <= pend_err;
          inst_last  <= 1'b1;
          state      <= HOLD_LAST;
        end
        HOLD_LAST: begin
          inst_valid <= 1'b0;
          state      <= EMPTY;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder: expected words are queued
// when a request is driven and compared as the consumer takes each word.
module tb_instruction_encoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_format;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_last;
  logic        inst_error;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic accepted;
  int   issue_cycles;

  always #5 clock = ~clock;

  instruction_encoder dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_format (req_format),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_last  (inst_last),
    .inst_error (inst_error)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input logic [31:0] word, input logic last, input logic err);
    exp_t e;
    e.word = word;
    e.last = last;
    e.err  = err;
    sb.push_back(e);
  endtask

  // One clock: sample at the falling edge, retire a taken word, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    accepted = req_valid && req_ready;
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_word", inst, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check_output("word",       inst,              e.word);
        check_output("word_last",  {31'd0, inst_last},  {31'd0, e.last});
        check_output("word_error", {31'd0, inst_error}, {31'd0, e.err});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
    req_format   = fmt;
    req_opcode   = op;
    req_funct3   = f3;
    req_rd       = rd;
    req_rs1      = rs1;
    req_rs2      = rs2;
    req_imm      = imm;
    req_valid    = 1'b1;
    issue_cycles = 0;
    do begin
      cycle();
      issue_cycles++;
    end while (!accepted && issue_cycles < 50);
    check_output("accept_timeout", {31'd0, accepted}, 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    inst_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    check_output("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_format = 3'd0;
    req_opcode = 7'd0;
    req_funct3 = 3'd0;
    req_rd     = 5'd0;
    req_rs1    = 5'd0;
    req_rs2    = 5'd0;
    req_imm    = 32'd0;
    inst_ready = 1'b0;
    accepted   = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    check_output("rst_valid", {31'd0, inst_valid}, 32'd0);
    check_output("rst_inst",  inst,                32'd0);
    check_output("rst_last",  {31'd0, inst_last},  32'd0);
    check_output("rst_error", {31'd0, inst_error}, 32'd0);
    check_output("rst_ready", {31'd0, req_ready},  32'd1);

    // ADDI x5,x6,-1 with one-cycle latency
    inst_ready = 1'b1;
    push_word(32'hFFF30293, 1'b1, 1'b0);
    apply_stimulus(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    check_output("addi_latency_valid", {31'd0, inst_valid}, 32'd1);
    check_output("addi_latency_inst",  inst,                32'hFFF30293);
    drain();

    // Stores, branches, jumps and range boundaries
    push_word(32'h0020A423, 1'b1, 1'b0);
    apply_stimulus(3'd1, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8);
    push_word(32'h00000163, 1'b1, 1'b1);
    apply_stimulus(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3);
    push_word(32'h00001037, 1'b1, 1'b1);
    apply_stimulus(3'd3, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_1001);
    push_word(32'h00000000, 1'b1, 1'b1);
    apply_stimulus(3'd7, 7'h13, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0000_0001);
    push_word(32'h001000EF, 1'b1, 1'b0);
    apply_stimulus(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    push_word(32'h8000006F, 1'b1, 1'b0);
    apply_stimulus(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000);
    push_word(32'h80000013, 1'b1, 1'b1);
    apply_stimulus(3'd0, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0800);
    drain();

    // Two-word LI with the consumer stalled: first word must hold
    inst_ready = 1'b0;
    push_word(32'h12346537, 1'b0, 1'b0);
    push_word(32'hFFF50513, 1'b1, 1'b0);
    apply_stimulus(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_output("stall_valid", {31'd0, inst_valid}, 32'd1);
      check_output("stall_inst",  inst,                32'h12346537);
      check_output("stall_last",  {31'd0, inst_last},  32'd0);
      check_output("stall_ready", {31'd0, req_ready},  32'd0);
      @(posedge clock);
      #1;
    end
    inst_ready = 1'b1;
    @(negedge clock);
    check_output("hold_first_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    sb.delete(0);
    check_output("li_second_inst", inst,               32'hFFF50513);
    check_output("li_second_last", {31'd0, inst_last}, 32'd1);
    drain();

    // Back-to-back single-word LIs stream with no bubble
    inst_ready = 1'b1;
    push_word(32'h7FF00093, 1'b1, 1'b0);
    apply_stimulus(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_07FF);
    push_word(32'h000010B7, 1'b1, 1'b0);
    apply_stimulus(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000);
    check_output("no_bubble_cycles", issue_cycles, 32'd1);
    check_output("no_bubble_valid",  {31'd0, inst_valid}, 32'd1);
    drain();

    // Reset while the LUI is held discards the pending ADDI
    inst_ready = 1'b0;
    push_word(32'h12346537, 1'b0, 1'b0);
    push_word(32'hFFF50513, 1'b1, 1'b0);
    apply_stimulus(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF);
    check_output("pre_reset_inst", inst, 32'h12346537);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sb.delete();
    check_output("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    check_output("mid_rst_inst",  inst,                32'd0);
    check_output("mid_rst_last",  {31'd0, inst_last},  32'd0);
    check_output("mid_rst_error", {31'd0, inst_error}, 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output("post_rst_idle", {31'd0, inst_valid}, 32'd0);
    end
    push_word(32'hFFF30293, 1'b1, 1'b0);
    apply_stimulus(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
